// File: rtl/m68k_bus_master.sv
// 68000 asynchronous bus initiator: turns an internal request into an AS/UDS/LDS/RW cycle terminated by DTACK or BERR.
// Optional `define BERR_TIMEOUT_EN adds a WAIT-state watchdog that ends a silent cycle as a bus error after TIMEOUT clocks.
module m68k_bus_master #(
`ifdef BERR_TIMEOUT_EN
  parameter int TIMEOUT  = 255,
`endif
  parameter int RECOVERY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [22:0] REQ_A,
  input  logic        REQ_UDS,
  input  logic        REQ_LDS,
  input  logic [15:0] REQ_WDATA,
  input  logic        GRANT,
  output logic        BUSY,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic [22:0] A_OUT,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic [15:0] D_IN,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  input  logic        DTACK,
  input  logic        BERR
);

  typedef enum logic [3:0] {
    S_IDLE, S_REJECT, S_ADDR, S_ASSERT, S_WDS, S_WAIT, S_DATA, S_NEGATE, S_RECOVER
  } state_t;

  localparam int REC_W = (RECOVERY > 1) ? $clog2(RECOVERY) : 1;

  state_t            state_q, state_d;
  logic              dt_s1_q, dt_s_q, be_s1_q, be_s_q;
  logic              err_flag_q, err_flag_d;
  logic [REC_W-1:0]  rec_cnt_q, rec_cnt_d;
  logic              rec_done;
  logic              timeout_hit;
  logic              ds_on;

  logic              lat_rw_q, lat_rw_d;
  logic [22:0]       lat_a_q, lat_a_d;
  logic              lat_uds_q, lat_uds_d;
  logic              lat_lds_q, lat_lds_d;
  logic [15:0]       lat_wdata_q, lat_wdata_d;

  logic              as_q, as_d, uds_q, uds_d, lds_q, lds_d, rw_q, rw_d;
  logic              d_oe_q, d_oe_d, ack_q, ack_d, err_q, err_d, busy_q, busy_d;
  logic [15:0]       rdata_q, rdata_d, d_out_q, d_out_d;
  logic [22:0]       a_out_q, a_out_d;

  assign rec_done = (int'(rec_cnt_q) >= RECOVERY - 1);

`ifdef BERR_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Saturates at TIMEOUT-1 so it never wraps; any state other than WAIT clears it.
  assign timeout_hit = (state_q == S_WAIT) && (int'(to_cnt_q) >= TIMEOUT - 1);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != S_WAIT) to_cnt_d = '0;
    else if (!timeout_hit) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, otherwise a path that skips it infers a latch.
  always_comb begin
    state_d     = state_q;
    err_flag_d  = err_flag_q;
    rec_cnt_d   = rec_cnt_q;
    lat_rw_d    = lat_rw_q;
    lat_a_d     = lat_a_q;
    lat_uds_d   = lat_uds_q;
    lat_lds_d   = lat_lds_q;
    lat_wdata_d = lat_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (REQ && GRANT) begin
          lat_rw_d    = REQ_RW;
          lat_a_d     = REQ_A;
          lat_uds_d   = REQ_UDS;
          lat_lds_d   = REQ_LDS;
          lat_wdata_d = REQ_WDATA;
          err_flag_d  = 1'b0;
          state_d     = (REQ_UDS && REQ_LDS) ? S_REJECT : S_ADDR;
        end
      end
      S_REJECT: state_d = S_IDLE;
      S_ADDR:   state_d = S_ASSERT;
      S_ASSERT: state_d = lat_rw_q ? S_WAIT : S_WDS;
      S_WDS:    state_d = S_WAIT;
      S_WAIT: begin
        if (!be_s_q) begin
          err_flag_d = 1'b1;
          state_d    = S_NEGATE;
        end else if (!dt_s_q) begin
          state_d = S_DATA;
        end else if (timeout_hit) begin
          err_flag_d = 1'b1;
          state_d    = S_NEGATE;
        end
      end
      S_DATA: state_d = S_NEGATE;
      S_NEGATE: begin
        rec_cnt_d = '0;
        state_d   = S_RECOVER;
      end
      S_RECOVER: begin
        if (dt_s_q && be_s_q && rec_done) state_d = S_IDLE;
        else if (!rec_done)               rec_cnt_d = rec_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pins are registered from the current state, so they follow the state register by one clock.
  assign ds_on = ((state_q == S_ASSERT) && lat_rw_q) || (state_q inside {S_WDS, S_WAIT, S_DATA});

  always_comb begin
    as_d    = !(state_q inside {S_ASSERT, S_WDS, S_WAIT, S_DATA});
    uds_d   = ds_on ? lat_uds_q : 1'b1;
    lds_d   = ds_on ? lat_lds_q : 1'b1;
    rw_d    = rw_q;
    a_out_d = a_out_q;
    d_out_d = d_out_q;
    d_oe_d  = d_oe_q;
    ack_d   = (state_q == S_REJECT) || (state_q == S_NEGATE);
    err_d   = (state_q == S_REJECT) || ((state_q == S_NEGATE) && err_flag_q);
    rdata_d = ((state_q == S_DATA) && lat_rw_q) ? D_IN : rdata_q;
    busy_d  = (state_d != S_IDLE);
    if (state_q == S_ADDR) begin
      rw_d    = lat_rw_q;
      a_out_d = lat_a_q;
      d_oe_d  = !lat_rw_q;
      if (!lat_rw_q) d_out_d = lat_wdata_q;
    end else if (state_q == S_RECOVER) begin
      rw_d   = 1'b1;
      d_oe_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      dt_s1_q    <= 1'b1;
      dt_s_q     <= 1'b1;
      be_s1_q    <= 1'b1;
      be_s_q     <= 1'b1;
      err_flag_q <= 1'b0;
      rec_cnt_q  <= '0;
      as_q       <= 1'b1;
      uds_q      <= 1'b1;
      lds_q      <= 1'b1;
      rw_q       <= 1'b1;
      d_oe_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      a_out_q    <= '0;
      d_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      dt_s1_q    <= DTACK;
      dt_s_q     <= dt_s1_q;
      be_s1_q    <= BERR;
      be_s_q     <= be_s1_q;
      err_flag_q <= err_flag_d;
      rec_cnt_q  <= rec_cnt_d;
      as_q       <= as_d;
      uds_q      <= uds_d;
      lds_q      <= lds_d;
      rw_q       <= rw_d;
      d_oe_q     <= d_oe_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      a_out_q    <= a_out_d;
      d_out_q    <= d_out_d;
    end
  end

  // NOTE: the request latch needs no reset; it is always loaded in IDLE before any state reads it.
  always_ff @(posedge CLK) begin
    lat_rw_q    <= lat_rw_d;
    lat_a_q     <= lat_a_d;
    lat_uds_q   <= lat_uds_d;
    lat_lds_q   <= lat_lds_d;
    lat_wdata_q <= lat_wdata_d;
  end

  assign AS    = as_q;
  assign UDS   = uds_q;
  assign LDS   = lds_q;
  assign RW    = rw_q;
  assign D_OE  = d_oe_q;
  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign BUSY  = busy_q;
  assign RDATA = rdata_q;
  assign A_OUT = a_out_q;
  assign D_OUT = d_out_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Scoreboard bench for m68k_bus_master: requests push {ERR, RDATA} expectations, a monitor pops them on every ACK.
module tb_m68k_bus_master;

  typedef struct packed {
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  typedef struct {
    int lat_ack; int lat_as; int lat_lds;
    int as_n; int uds_n; int lds_n; int doe_n; int ack_n;
    int rw_bad; int a_bad; int d_bad;
  } stats_t;

  logic        CLK = 1'b0;
  logic        RST, REQ, REQ_RW, REQ_UDS, REQ_LDS, GRANT;
  logic [22:0] REQ_A;
  logic [15:0] REQ_WDATA;
  logic        BUSY, ACK, ERR, D_OE, AS, UDS, LDS, RW, DTACK, BERR;
  logic [15:0] RDATA, D_OUT, D_IN;
  logic [22:0] A_OUT;

  logic        resp_en    = 1'b0;
  int          resp_delay = 0;
  logic [15:0] resp_data  = 16'h0000;
  logic        resp_dtack = 1'b1;
  logic        man_dtack  = 1'b1;
  logic        man_berr   = 1'b1;
  int          as_cnt     = 0;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] last_rd = 16'h0000;

  always #5 CLK = ~CLK;

  assign DTACK = resp_dtack & man_dtack;
  assign BERR  = man_berr;
  assign D_IN  = DTACK ? 16'hDEAD : resp_data;

  m68k_bus_master #(
`ifdef BERR_TIMEOUT_EN
    .TIMEOUT(8),
`endif
    .RECOVERY(1)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_A(REQ_A),
    .REQ_UDS(REQ_UDS), .REQ_LDS(REQ_LDS), .REQ_WDATA(REQ_WDATA), .GRANT(GRANT),
    .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .A_OUT(A_OUT),
    .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN), .AS(AS), .UDS(UDS), .LDS(LDS),
    .RW(RW), .DTACK(DTACK), .BERR(BERR)
  );

  // Responder: asserts DTACK once AS has been low for more than resp_delay samples, releases it when AS rises.
  always @(negedge CLK) begin
    if (resp_en && !AS) begin
      as_cnt = as_cnt + 1;
      if (as_cnt > resp_delay) resp_dtack = 1'b0;
    end else begin
      as_cnt     = 0;
      resp_dtack = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input string tag);
    logic idle = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge CLK);
      if (!BUSY) begin idle = 1'b1; break; end
    end
    check({tag, "_idle"}, idle, 1'b1);
  endtask

  task automatic run_req(input string tag, input logic rw, input logic [22:0] a, input logic u,
                         input logic l, input logic [15:0] wd, input logic e_err,
                         input logic [15:0] e_rd, output stats_t s);
    logic acked = 1'b0;
    int   idle_n = 0;
    s = '{default: 0};
    s.lat_ack = -1; s.lat_as = -1; s.lat_lds = -1;
    exp_q.push_back(exp_t'({e_err, e_rd}));
    @(negedge CLK);
    REQ = 1'b1; REQ_RW = rw; REQ_A = a; REQ_UDS = u; REQ_LDS = l; REQ_WDATA = wd;
    for (int n = 1; n <= 300; n++) begin
      @(negedge CLK);
      if (!AS) begin
        s.as_n++;
        if (s.lat_as < 0) s.lat_as = n;
        if (RW !== rw) s.rw_bad++;
        if (A_OUT !== a) s.a_bad++;
      end
      if (rw && RW !== 1'b1) s.rw_bad++;
      if (!UDS) s.uds_n++;
      if (!LDS) begin s.lds_n++; if (s.lat_lds < 0) s.lat_lds = n; end
      if (D_OE) begin s.doe_n++; if (D_OUT !== wd) s.d_bad++; end
      if (ACK) begin
        s.ack_n++;
        if (!acked) s.lat_ack = n;
        acked = 1'b1; REQ = 1'b0; man_dtack = 1'b1;
      end
      if (acked && !BUSY) idle_n++;
      if (idle_n == 3) break;
    end
    REQ = 1'b0;
    check({tag, "_acked"}, acked, 1'b1);
  endtask

  stats_t s;
  logic   flag;
  int     cnt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; REQ = 1'b0; REQ_RW = 1'b1; REQ_A = '0; REQ_UDS = 1'b1; REQ_LDS = 1'b1;
    REQ_WDATA = '0; GRANT = 1'b1;

    fork
      forever begin
        @(negedge CLK);
        if (RST && ACK) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", ACK, 1'b0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_err", ERR, e.err);
            check("sb_rdata", RDATA, e.rdata);
          end
        end
      end
    join_none

    repeat (3) @(negedge CLK);
    check("rst_as", AS, 1'b1);    check("rst_uds", UDS, 1'b1);  check("rst_lds", LDS, 1'b1);
    check("rst_rw", RW, 1'b1);    check("rst_doe", D_OE, 1'b0); check("rst_ack", ACK, 1'b0);
    check("rst_err", ERR, 1'b0);  check("rst_busy", BUSY, 1'b0);
    check("rst_rdata", RDATA, 16'h0); check("rst_a", A_OUT, 23'h0); check("rst_dout", D_OUT, 16'h0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Read, DTACK four cycles after AS falls.
    resp_en = 1'b1; resp_delay = 4; resp_data = 16'hA55A;
    run_req("rd", 1'b1, 23'h7FC101, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hA55A, s);
    last_rd = 16'hA55A;
    check("rd_lat_as", s.lat_as, 3);  check("rd_lat_ack", s.lat_ack, 12);
    check("rd_as_n", s.as_n, 9);      check("rd_uds_n", s.uds_n, 9);  check("rd_lds_n", s.lds_n, 9);
    check("rd_ack_n", s.ack_n, 1);    check("rd_rw_bad", s.rw_bad, 0);
    check("rd_a_bad", s.a_bad, 0);    check("rd_doe_n", s.doe_n, 0);

    // Write, lower byte only, DTACK two cycles after AS falls.
    resp_delay = 2;
    run_req("wr", 1'b0, 23'h400000, 1'b1, 1'b0, 16'h1234, 1'b0, last_rd, s);
    check("wr_lat_as", s.lat_as, 3);  check("wr_lat_lds", s.lat_lds, 4); check("wr_lat_ack", s.lat_ack, 10);
    check("wr_as_n", s.as_n, 7);      check("wr_lds_n", s.lds_n, 6);     check("wr_uds_n", s.uds_n, 0);
    check("wr_doe_n", s.doe_n, 9);    check("wr_d_bad", s.d_bad, 0);     check("wr_a_bad", s.a_bad, 0);
    check("wr_rw_bad", s.rw_bad, 0);  check("wr_ack_n", s.ack_n, 1);

    // Minimum latency with DTACK already low.
    resp_en = 1'b0; resp_data = 16'h0F0F; man_dtack = 1'b0;
    repeat (3) @(negedge CLK);
    run_req("minrd", 1'b1, 23'h000123, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0F0F, s);
    last_rd = 16'h0F0F;
    check("minrd_lat_as", s.lat_as, 3); check("minrd_lat_ack", s.lat_ack, 6); check("minrd_as_n", s.as_n, 3);
    man_dtack = 1'b0;
    repeat (3) @(negedge CLK);
    run_req("minwr", 1'b0, 23'h000200, 1'b0, 1'b1, 16'hBEEF, 1'b0, last_rd, s);
    check("minwr_lat_ack", s.lat_ack, 7); check("minwr_d_bad", s.d_bad, 0);

    // BERR and DTACK together; RECOVER must hold until both are released.
    resp_data = 16'h5555;
    exp_q.push_back(exp_t'({1'b1, last_rd}));
    @(negedge CLK);
    REQ = 1'b1; REQ_RW = 1'b1; REQ_A = 23'h012345; REQ_UDS = 1'b0; REQ_LDS = 1'b0;
    flag = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (!AS) begin flag = 1'b1; break; end
    end
    check("berr_as_fell", flag, 1'b1);
    man_dtack = 1'b0; man_berr = 1'b0;
    flag = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (ACK) begin flag = 1'b1; break; end
    end
    REQ = 1'b0;
    check("berr_acked", flag, 1'b1);
    repeat (5) @(negedge CLK);
    check("berr_hold_busy", BUSY, 1'b1);
    check("berr_hold_as", AS, 1'b1);
    man_dtack = 1'b1; man_berr = 1'b1;
    repeat (2) @(negedge CLK);
    check("berr_release_busy_hi", BUSY, 1'b1);
    @(negedge CLK);
    check("berr_release_busy_lo", BUSY, 1'b0);

    // Rejected request: no strobes at all.
    run_req("rej", 1'b1, 23'h000007, 1'b1, 1'b1, 16'h0000, 1'b1, last_rd, s);
    check("rej_lat_ack", s.lat_ack, 2); check("rej_as_n", s.as_n, 0);
    check("rej_ack_n", s.ack_n, 1);     check("rej_doe_n", s.doe_n, 0);

    // Arbitration: no cycle without GRANT; dropping GRANT mid-cycle does not abort.
    resp_en = 1'b1; resp_delay = 0; resp_data = 16'hC3C3;
    GRANT = 1'b0;
    exp_q.push_back(exp_t'({1'b0, 16'hC3C3}));
    @(negedge CLK);
    REQ = 1'b1; REQ_RW = 1'b1; REQ_A = 23'h00ABCD; REQ_UDS = 1'b0; REQ_LDS = 1'b1;
    flag = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (BUSY || !AS) flag = 1'b1;
    end
    check("grant_low_blocks", flag, 1'b0);
    GRANT = 1'b1;
    flag = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge CLK);
      if (BUSY) GRANT = 1'b0;
      if (ACK) begin flag = 1'b1; break; end
    end
    REQ = 1'b0; GRANT = 1'b1;
    check("grant_drop_acked", flag, 1'b1);
    last_rd = 16'hC3C3;
    wait_idle("grant");

    // Reset in the middle of a write held in WAIT.
    resp_en = 1'b0;
    @(negedge CLK);
    REQ = 1'b1; REQ_RW = 1'b0; REQ_A = 23'h000003; REQ_UDS = 1'b0; REQ_LDS = 1'b0; REQ_WDATA = 16'h7777;
    flag = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (!AS) begin flag = 1'b1; break; end
    end
    check("mrst_as_fell", flag, 1'b1);
    repeat (3) @(negedge CLK);
    RST = 1'b0; REQ = 1'b0;
    @(negedge CLK);
    check("mrst_as", AS, 1'b1);     check("mrst_uds", UDS, 1'b1); check("mrst_lds", LDS, 1'b1);
    check("mrst_doe", D_OE, 1'b0);  check("mrst_ack", ACK, 1'b0); check("mrst_busy", BUSY, 1'b0);
    check("mrst_rdata", RDATA, 16'h0);
    RST = 1'b1;
    last_rd = 16'h0000;
    cnt = 0;
    repeat (4) begin
      @(negedge CLK);
      if (ACK) cnt++;
    end
    check("mrst_no_ack", cnt, 0);
    resp_en = 1'b1; resp_delay = 1; resp_data = 16'h6969;
    run_req("post_rst", 1'b1, 23'h0055AA, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h6969, s);
    last_rd = 16'h6969;
    check("post_rst_ack_n", s.ack_n, 1); check("post_rst_lat_as", s.lat_as, 3);

    // Silent responder.
    resp_en = 1'b0;
`ifdef BERR_TIMEOUT_EN
    run_req("tmo", 1'b1, 23'h000077, 1'b0, 1'b0, 16'h0000, 1'b1, last_rd, s);
    check("tmo_lat_ack", s.lat_ack, 12); check("tmo_ack_n", s.ack_n, 1);
`else
    @(negedge CLK);
    REQ = 1'b1; REQ_RW = 1'b1; REQ_A = 23'h000077; REQ_UDS = 1'b0; REQ_LDS = 1'b0;
    cnt = 0;
    repeat (1000) begin
      @(negedge CLK);
      if (ACK) cnt++;
    end
    check("no_tmo_ack", cnt, 0);
    check("no_tmo_as_held", AS, 1'b0);
    RST = 1'b0; REQ = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    check("no_tmo_reset_busy", BUSY, 1'b0);
`endif

    repeat (3) @(negedge CLK);
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
